// File: rtl/dma_mem_endpoint.sv
`timescale 1ns/1ps
// dma_mem_endpoint: memory-side endpoint of the DMA nibble path.
// It accepts an address/length descriptor. In write mode it packs incoming nibbles
// (low nibble first) into bytes and stores them in an internal byte RAM. In read
// mode it streams RAM bytes back out as nibbles, low nibble first.
// Every output is decoded from registered state, so no input reaches an output
// through combinational logic.
module dma_mem_endpoint #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode,
  input  logic        addr_in_valid,
  output logic        addr_in_enable,
  input  logic [31:0] addr_in,
  input  logic [31:0] len_in,
  input  logic        dma_to_mem_valid,
  output logic        dma_to_mem_enable,
  input  logic [3:0]  mem_in_socket,
  output logic        mem_to_dma_valid,
  input  logic        mem_to_dma_enable,
  output logic [3:0]  mem_out_socket,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;   // 0: low nibble next, 1: high nibble next
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic [3:0]          held_q,  held_d;    // low nibble waiting for its high partner
  logic                ram_we;
  logic [7:0]          ram_q [2**ADDR_W];
  logic [7:0]          rd_byte;

  // Address bits above the RAM depth are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[31:ADDR_W];

  // Next-state logic: descriptor capture, nibble handshakes, and the end-of-transfer decision.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that skips an assignment cannot infer a latch.
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    len_d   = len_q;
    held_d  = held_q;
    ram_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (addr_in_valid) begin
          addr_d  = addr_in[ADDR_W-1:0];
          len_d   = len_in[LEN_W-1:0];
          phase_d = 1'b0;
          if (len_in[LEN_W-1:0] == '0) state_d = S_DONE;
          else                         state_d = mode ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (dma_to_mem_valid) begin
          if (!phase_q) begin
            held_d  = mem_in_socket;
            phase_d = 1'b1;
          end else begin
            ram_we  = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            len_d   = len_q - LEN_W'(1);
            phase_d = 1'b0;
            if (len_q == LEN_W'(1)) state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (mem_to_dma_enable) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            len_d   = len_q - LEN_W'(1);
            phase_d = 1'b0;
            if (len_q == LEN_W'(1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!resetn) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      held_q  <= held_d;
    end
  end

  // Byte RAM write port: stores the packed byte when the high nibble is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset, so it maps onto plain memory. Only the write is blocked while resetn is low.
    if (resetn && ram_we) ram_q[addr_q] <= {mem_in_socket, held_q};
  end

  assign rd_byte = ram_q[addr_q];

  // Output decode from registered state only.
  always_comb begin
    addr_in_enable    = (state_q == S_IDLE);
    dma_to_mem_enable = (state_q == S_WRITE);
    mem_to_dma_valid  = (state_q == S_READ);
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    mem_out_socket    = 4'h0;
    if (state_q == S_READ) mem_out_socket = phase_q ? rd_byte[7:4] : rd_byte[3:0];
  end

endmodule

// File: tb/tb_dma_mem_endpoint.sv
`timescale 1ns/1ps
// tb_dma_mem_endpoint: directed and randomized transfers checked against a byte-array model.
module tb_dma_mem_endpoint;

  logic        clk;
  logic        resetn;
  logic        mode;
  logic        addr_in_valid;
  logic        addr_in_enable;
  logic [31:0] addr_in;
  logic [31:0] len_in;
  logic        dma_to_mem_valid;
  logic        dma_to_mem_enable;
  logic [3:0]  mem_in_socket;
  logic        mem_to_dma_valid;
  logic        mem_to_dma_enable;
  logic [3:0]  mem_out_socket;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [256];   // reference image of the RAM
  logic [7:0] wbuf [$];          // bytes for the next write transfer

  dma_mem_endpoint dut (
    .clk               (clk),
    .resetn            (resetn),
    .mode              (mode),
    .addr_in_valid     (addr_in_valid),
    .addr_in_enable    (addr_in_enable),
    .addr_in           (addr_in),
    .len_in            (len_in),
    .dma_to_mem_valid  (dma_to_mem_valid),
    .dma_to_mem_enable (dma_to_mem_enable),
    .mem_in_socket     (mem_in_socket),
    .mem_to_dma_valid  (mem_to_dma_valid),
    .mem_to_dma_enable (mem_to_dma_enable),
    .mem_out_socket    (mem_out_socket),
    .busy              (busy),
    .done              (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Checks the outputs in the idle state (also the state right after reset).
  task automatic check_idle(input string tag);
    check({tag, "_aen"}, addr_in_enable, 1);
    check({tag, "_wen"}, dma_to_mem_enable, 0);
    check({tag, "_rvl"}, mem_to_dma_valid, 0);
    check({tag, "_sock"}, mem_out_socket, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Offers a descriptor with random junk in the ignored address bits, then scrambles the inputs.
  task automatic start_desc(input bit m, input logic [7:0] a, input int len);
    @(negedge clk);
    check("desc_rdy", addr_in_enable, 1);
    mode          = m;
    addr_in       = {24'($urandom), a};
    len_in        = len;
    addr_in_valid = 1'b1;
    @(negedge clk);
    addr_in_valid = 1'b0;
    addr_in       = $urandom;
    len_in        = $urandom;
    mode          = 1'($urandom);
    if (len == 0) begin
      check("len0_done", done, 1);
      check("len0_wen", dma_to_mem_enable, 0);
      check("len0_rvl", mem_to_dma_valid, 0);
      @(negedge clk);
      check("len0_done_clr", done, 0);
      check("len0_aen", addr_in_enable, 1);
    end else begin
      check("desc_busy", busy, 1);
      check("desc_aen_low", addr_in_enable, 0);
    end
  endtask

  // Expected at the negedge right after the last handshake: a one-cycle done pulse, then idle.
  task automatic finish_xfer(input string tag);
    @(negedge clk);
    addr_in_valid     = 1'b0;
    dma_to_mem_valid  = 1'b0;
    mem_to_dma_enable = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_done_aen"}, addr_in_enable, 0);
    check({tag, "_done_en"}, {dma_to_mem_enable, mem_to_dma_valid}, 0);
    @(negedge clk);
    check({tag, "_post_done"}, done, 0);
    check({tag, "_post_aen"}, addr_in_enable, 1);
  endtask

  // Writes wbuf starting at address a, optionally with random valid gaps and stray descriptors.
  task automatic do_write(input logic [7:0] a, input bit gaps);
    int n = 2 * wbuf.size();
    int idx = 0;
    int cyc = 0;
    logic [7:0] b;
    start_desc(1'b1, a, wbuf.size());
    if (n == 0) return;
    while (idx < n && cyc < 4 * n + 20) begin
      @(negedge clk);
      cyc++;
      addr_in_valid = 1'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) begin
        dma_to_mem_valid = 1'b0;
        mem_in_socket    = 4'($urandom);
      end else begin
        b                = wbuf[idx / 2];
        dma_to_mem_valid = 1'b1;
        mem_in_socket    = (idx % 2 == 0) ? b[3:0] : b[7:4];
      end
      if (dma_to_mem_valid && dma_to_mem_enable) idx++;
    end
    check("wr_accepts", idx, n);
    for (int i = 0; i < wbuf.size(); i++) model_mem[(a + i) % 256] = wbuf[i];
    finish_xfer("wr");
  endtask

  // Reads len bytes from address a and compares every valid nibble, held ones included.
  task automatic do_read(input logic [7:0] a, input int len, input bit gaps);
    logic [3:0] exp_q [$];
    logic [7:0] b;
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < len; i++) begin
      b = model_mem[(a + i) % 256];
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
    end
    start_desc(1'b0, a, len);
    if (len == 0) return;
    while (idx < 2 * len && cyc < 8 * len + 20) begin
      @(negedge clk);
      cyc++;
      addr_in_valid     = 1'($urandom);
      mem_to_dma_enable = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_to_dma_valid) check($sformatf("rd_nib%0d", idx), mem_out_socket, exp_q[idx]);
      else                  check("rd_valid", mem_to_dma_valid, 1);
      if (mem_to_dma_valid && mem_to_dma_enable) idx++;
    end
    check("rd_accepts", idx, 2 * len);
    finish_xfer("rd");
  endtask

  initial begin
    resetn            = 1'b0;
    mode              = 1'b0;
    addr_in_valid     = 1'b0;
    addr_in           = '0;
    len_in            = '0;
    dma_to_mem_valid  = 1'b0;
    mem_in_socket     = '0;
    mem_to_dma_enable = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    resetn = 1'b1;

    // Basic write then read back of two bytes.
    wbuf = '{8'hA5, 8'hC3};
    do_write(8'h10, 1'b0);
    do_read(8'h10, 2, 1'b0);

    // Zero-length descriptors in both modes.
    start_desc(1'b1, 8'h40, 0);
    start_desc(1'b0, 8'h40, 0);

    // Address wrap at the top of the RAM.
    wbuf = '{8'h11, 8'h22};
    do_write(8'hFF, 1'b0);
    do_read(8'hFF, 2, 1'b0);

    // Same traffic with random handshake gaps.
    wbuf = '{8'hA5, 8'hC3};
    do_write(8'h10, 1'b1);
    do_read(8'h10, 2, 1'b1);

    // Reset after one accepted nibble leaves the RAM untouched.
    wbuf = '{8'h5A};
    do_write(8'h20, 1'b0);
    start_desc(1'b1, 8'h20, 2);
    begin
      int cyc = 0;
      bit got = 1'b0;
      while (!got && cyc < 20) begin
        @(negedge clk);
        cyc++;
        dma_to_mem_valid = 1'b1;
        mem_in_socket    = 4'hF;
        got              = dma_to_mem_enable;
      end
      check("abort_accept", got, 1);
    end
    @(negedge clk);
    dma_to_mem_valid = 1'b0;
    resetn           = 1'b0;
    @(negedge clk);
    check_idle("abort");
    resetn = 1'b1;
    do_read(8'h20, 1, 1'b0);
    wbuf = '{8'h3C};
    do_write(8'h20, 1'b1);
    do_read(8'h20, 1, 1'b1);

    // Fill the whole RAM, then run random transfers, including one longer than the RAM.
    wbuf.delete();
    for (int i = 0; i < 256; i++) wbuf.push_back(8'($urandom));
    do_write(8'h00, 1'b1);
    wbuf.delete();
    for (int i = 0; i < 300; i++) wbuf.push_back(8'($urandom));
    do_write(8'hF0, 1'b0);
    do_read(8'hF0, 20, 1'b1);
    for (int t = 0; t < 30; t++) begin
      logic [7:0] a = 8'($urandom);
      int len = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        for (int i = 0; i < len; i++) wbuf.push_back(8'($urandom));
        do_write(a, 1'($urandom));
      end else begin
        do_read(a, len, 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
